// File: rtl/steer_pkg.sv
// Shared types and default constants for the lateral steering controller.
package steer_pkg;

    // Controller state, 2-bit encoding visible on steer_state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEER_L  = 2'd1,
        ST_STEER_R  = 2'd2,
        ST_RECENTER = 2'd3
    } steer_state_e;

    // Button command decoded on a frame strobe
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_L    = 2'd1,
        CMD_R    = 2'd2,
        CMD_BOTH = 2'd3
    } steer_cmd_e;

    localparam int unsigned DEF_OFFSET_W    = 11;
    localparam int unsigned DEF_MAX_OFFSET  = 80;
    localparam int unsigned DEF_VEL_W       = 4;
    localparam int unsigned DEF_VMIN        = 1;
    localparam int unsigned DEF_VMAX        = 6;
    localparam int unsigned DEF_ACCEL       = 1;
    localparam int unsigned DEF_CENTER_RATE = 2;

    // Exclusive left/right decode; both or neither map to BOTH/NONE
    function automatic steer_cmd_e decode_cmd(input logic left, input logic right);
        case ({left, right})
            2'b10:   return CMD_L;
            2'b01:   return CMD_R;
            2'b11:   return CMD_BOTH;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/steer_sat_step.sv
// Signed offset + delta computed one bit wider, then clamped to +/-MAX_OFFSET.
module steer_sat_step #(
    parameter int unsigned W          = 11,
    parameter int unsigned MAX_OFFSET = 80
) (
    input  logic signed [W-1:0] offset,
    input  logic signed [W-1:0] delta,
    output logic signed [W-1:0] result
);

    localparam logic signed [W:0] HI = (W+1)'(MAX_OFFSET);
    localparam logic signed [W:0] LO = -HI;

    logic signed [W:0] sum;

    // Widened add so the clamp sees the true sum before truncation
    always_comb begin
        sum = {offset[W-1], offset} + {delta[W-1], delta};
        if (sum > HI) begin
            result = W'(HI);
        end else if (sum < LO) begin
            result = W'(LO);
        end else begin
            result = W'(sum);
        end
    end

endmodule

// File: rtl/steering_ramp_controller.sv
// Per-frame lateral steering with velocity ramp and clamped offset.
// Optional auto-centering on release: define STEER_AUTOCENTER_EN.
module steering_ramp_controller #(
    parameter int unsigned OFFSET_W    = steer_pkg::DEF_OFFSET_W,
    parameter int unsigned MAX_OFFSET  = steer_pkg::DEF_MAX_OFFSET,
    parameter int unsigned VEL_W       = steer_pkg::DEF_VEL_W,
    parameter int unsigned VMIN        = steer_pkg::DEF_VMIN,
    parameter int unsigned VMAX        = steer_pkg::DEF_VMAX,
    parameter int unsigned ACCEL       = steer_pkg::DEF_ACCEL,
    parameter int unsigned CENTER_RATE = steer_pkg::DEF_CENTER_RATE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_pulse,
    input  logic                       left_btn,
    input  logic                       right_btn,
    output logic signed [OFFSET_W-1:0] lateral_offset,
    output logic        [VEL_W-1:0]    steer_vel,
    output logic        [1:0]          steer_state,
    output logic                       at_left_limit,
    output logic                       at_right_limit
);

    import steer_pkg::*;

    // Reject illegal parameter sets at elaboration
    if ((CENTER_RATE < 1) || (VMIN < 1) || (VMIN > VMAX) || (VMAX >= (1 << VEL_W)) ||
        ((MAX_OFFSET + VMAX) >= (1 << (OFFSET_W - 1)))) begin : g_bad_params
        $error("steering_ramp_controller: illegal parameter combination");
    end

    localparam logic signed [OFFSET_W-1:0] MAX_S   = OFFSET_W'(MAX_OFFSET);
    localparam logic        [VEL_W:0]      VMAX_X  = (VEL_W+1)'(VMAX);
    localparam logic        [VEL_W:0]      ACCEL_X = (VEL_W+1)'(ACCEL);
`ifdef STEER_AUTOCENTER_EN
    localparam logic signed [OFFSET_W-1:0] CR_S    = OFFSET_W'(CENTER_RATE);
`endif

    steer_state_e               state_q;
    steer_cmd_e                 cmd;
    logic        [VEL_W:0]      vel_sum;
    logic        [VEL_W-1:0]    vel_ramp;
    logic        [VEL_W-1:0]    vel_n;
    logic signed [OFFSET_W-1:0] delta;
    logic signed [OFFSET_W-1:0] step_result;

    // Button decode for the current strobe
    always_comb begin
        cmd = decode_cmd(left_btn, right_btn);
    end

    // Next velocity: restart at VMIN on a new direction, else ramp to VMAX
    always_comb begin
        vel_sum  = (VEL_W+1)'(steer_vel) + ACCEL_X;
        vel_ramp = (vel_sum > VMAX_X) ? VEL_W'(VMAX) : VEL_W'(vel_sum);
        if (((cmd == CMD_L) && (state_q == ST_STEER_L)) ||
            ((cmd == CMD_R) && (state_q == ST_STEER_R))) begin
            vel_n = vel_ramp;
        end else begin
            vel_n = VEL_W'(VMIN);
        end
    end

    // Signed step applied to the offset by the shared saturating adder
    always_comb begin
        delta = '0;
        case (cmd)
            CMD_L: delta = -OFFSET_W'(vel_n);
            CMD_R: delta = OFFSET_W'(vel_n);
`ifdef STEER_AUTOCENTER_EN
            CMD_NONE: begin
                if (lateral_offset > CR_S) begin
                    delta = -CR_S;
                end else if (lateral_offset < -CR_S) begin
                    delta = CR_S;
                end else begin
                    delta = -lateral_offset;
                end
            end
`endif
            default: delta = '0;
        endcase
    end

    steer_sat_step #(
        .W          (OFFSET_W),
        .MAX_OFFSET (MAX_OFFSET)
    ) u_sat_step (
        .offset (lateral_offset),
        .delta  (delta),
        .result (step_result)
    );

    // State, velocity and offset registers; only strobe cycles update
    always_ff @(posedge clk) begin
        if (reset) begin
            lateral_offset <= '0;
            steer_vel      <= '0;
            state_q        <= ST_IDLE;
        end else if (frame_pulse) begin
            case (cmd)
                CMD_L: begin
                    lateral_offset <= step_result;
                    steer_vel      <= vel_n;
                    state_q        <= ST_STEER_L;
                end
                CMD_R: begin
                    lateral_offset <= step_result;
                    steer_vel      <= vel_n;
                    state_q        <= ST_STEER_R;
                end
                CMD_NONE: begin
                    steer_vel <= '0;
`ifdef STEER_AUTOCENTER_EN
                    lateral_offset <= step_result;
                    state_q        <= (step_result != '0) ? ST_RECENTER : ST_IDLE;
`else
                    state_q        <= ST_IDLE;
`endif
                end
                default: begin
                    lateral_offset <= lateral_offset;
                end
            endcase
        end
    end

    // Limit flags decode the registered offset directly
    always_comb begin
        steer_state    = state_q;
        at_left_limit  = (lateral_offset == -MAX_S);
        at_right_limit = (lateral_offset == MAX_S);
    end

endmodule

// File: tb/tb_steering_ramp_controller.sv
// Scoreboard bench for steering_ramp_controller; reference model in plain integers.
module tb_steering_ramp_controller;

    localparam int OFFSET_W = 11;
    localparam int MAXO     = 80;
    localparam int VEL_W    = 4;
    localparam int VMIN     = 1;
    localparam int VMAX     = 6;
    localparam int ACCEL    = 1;
    localparam int CR       = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       frame_pulse;
    logic                       left_btn;
    logic                       right_btn;
    logic signed [OFFSET_W-1:0] lateral_offset;
    logic        [VEL_W-1:0]    steer_vel;
    logic        [1:0]          steer_state;
    logic                       at_left_limit;
    logic                       at_right_limit;

    typedef struct {
        int off;
        int vel;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   m_off = 0;
    int   m_vel = 0;
    int   m_st  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    steering_ramp_controller dut (
        .clk            (clk),
        .reset          (reset),
        .frame_pulse    (frame_pulse),
        .left_btn       (left_btn),
        .right_btn      (right_btn),
        .lateral_offset (lateral_offset),
        .steer_vel      (steer_vel),
        .steer_state    (steer_state),
        .at_left_limit  (at_left_limit),
        .at_right_limit (at_right_limit)
    );

    always #5 clk = ~clk;

    // Behavioural reference: one frame of the steering rules
    task automatic model_frame(input bit l, input bit r);
        int vn;
        if (l && !r) begin
            vn    = (m_st == 1) ? ((m_vel + ACCEL > VMAX) ? VMAX : m_vel + ACCEL) : VMIN;
            m_off = (m_off - vn < -MAXO) ? -MAXO : m_off - vn;
            m_vel = vn;
            m_st  = 1;
        end else if (r && !l) begin
            vn    = (m_st == 2) ? ((m_vel + ACCEL > VMAX) ? VMAX : m_vel + ACCEL) : VMIN;
            m_off = (m_off + vn > MAXO) ? MAXO : m_off + vn;
            m_vel = vn;
            m_st  = 2;
        end else if (!l && !r) begin
            m_vel = 0;
`ifdef STEER_AUTOCENTER_EN
            if (m_off > CR) m_off = m_off - CR;
            else if (m_off < -CR) m_off = m_off + CR;
            else m_off = 0;
            m_st = (m_off != 0) ? 3 : 0;
`else
            m_st = 0;
`endif
        end
    endtask

    // Model advances on each edge and queues the expected post-edge outputs
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_off = 0;
            m_vel = 0;
            m_st  = 0;
        end else if (frame_pulse) begin
            model_frame(left_btn, right_btn);
        end
        e.off = m_off;
        e.vel = m_vel;
        e.st  = m_st;
        exp_q.push_back(e);
    end

    // Monitor: compare the registered outputs half a cycle after each edge
    always @(negedge clk) begin
        exp_t e;
        int   a_off;
        bit   exp_l;
        bit   exp_r;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            a_off = int'(lateral_offset);
            exp_l = (e.off == -MAXO);
            exp_r = (e.off == MAXO);
            n_checks++;
            if (a_off != e.off || int'(steer_vel) != e.vel || int'(steer_state) != e.st ||
                at_left_limit !== exp_l || at_right_limit !== exp_r) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: off=%0d vel=%0d st=%0d ll=%0b rl=%0b, expected off=%0d vel=%0d st=%0d ll=%0b rl=%0b",
                         $time, a_off, steer_vel, steer_state, at_left_limit, at_right_limit,
                         e.off, e.vel, e.st, exp_l, exp_r);
            end
        end
    end

    // Directed check against a constant taken from the expected behaviour
    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            frame_pulse = 1'b0;
        end
    endtask

    task automatic strobe(input bit l, input bit r);
        @(posedge clk);
        #2;
        left_btn    = l;
        right_btn   = r;
        frame_pulse = 1'b1;
        @(posedge clk);
        #2;
        frame_pulse = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int exp_off;
        reset       = 1'b1;
        frame_pulse = 1'b0;
        left_btn    = 1'b0;
        right_btn   = 1'b0;
        idle_cycles(3);
        chk("reset_offset", int'(lateral_offset), 0);
        chk("reset_vel", int'(steer_vel), 0);
        chk("reset_state", int'(steer_state), 0);
        chk("reset_flags", int'({at_left_limit, at_right_limit}), 0);
        reset = 1'b0;

        // Right ramp from rest
        exp_off = 0;
        for (int i = 1; i <= 5; i++) begin
            strobe(1'b0, 1'b1);
            exp_off += i;
            chk("ramp_vel", int'(steer_vel), i);
            chk("ramp_offset", int'(lateral_offset), exp_off);
            chk("ramp_state", int'(steer_state), 2);
        end

        // Reversal restarts at VMIN
        strobe(1'b1, 1'b0);
        chk("rev_vel", int'(steer_vel), 1);
        chk("rev_offset", int'(lateral_offset), 14);
        chk("rev_state", int'(steer_state), 1);

        // Release from 15
        do_reset();
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0);
`ifdef STEER_AUTOCENTER_EN
        chk("release_offset", int'(lateral_offset), 0);
`else
        chk("release_offset", int'(lateral_offset), 15);
`endif
        chk("release_state", int'(steer_state), 0);
        chk("release_vel", int'(steer_vel), 0);

        // Pin at the right limit and keep pushing
        for (int i = 0; i < 25; i++) strobe(1'b0, 1'b1);
        chk("limit_offset", int'(lateral_offset), MAXO);
        chk("limit_vel", int'(steer_vel), VMAX);
        chk("limit_flag", int'(at_right_limit), 1);

        // Both held freezes; held button without strobes is ignored
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1);
        chk("both_offset", int'(lateral_offset), MAXO);
        chk("both_state", int'(steer_state), 2);
        left_btn  = 1'b0;
        right_btn = 1'b1;
        idle_cycles(100);
        chk("nostrobe_offset", int'(lateral_offset), MAXO);
        chk("nostrobe_vel", int'(steer_vel), VMAX);

        // Reach 40, then reset collides with a strobe
        do_reset();
        for (int i = 0; i < 8; i++) strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        chk("pre_reset_offset", int'(lateral_offset), 40);
        @(posedge clk);
        #2;
        reset       = 1'b1;
        frame_pulse = 1'b1;
        right_btn   = 1'b1;
        left_btn    = 1'b0;
        @(posedge clk);
        #2;
        reset       = 1'b0;
        frame_pulse = 1'b0;
        chk("collide_offset", int'(lateral_offset), 0);
        chk("collide_vel", int'(steer_vel), 0);
        chk("collide_state", int'(steer_state), 0);
        strobe(1'b0, 1'b1);
        chk("after_reset_offset", int'(lateral_offset), 1);
        chk("after_reset_vel", int'(steer_vel), 1);

        // Random segments of held buttons with idle gaps and rare resets
        for (int s = 0; s < 80; s++) begin
            bit [1:0] btn;
            int       len;
            btn = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                @(posedge clk);
                #2;
                left_btn    = btn[1];
                right_btn   = btn[0];
                frame_pulse = 1'b1;
                reset       = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    left_btn  = $urandom_range(0, 1) != 0;
                    right_btn = $urandom_range(0, 1) != 0;
                end
                @(posedge clk);
                #2;
                frame_pulse = 1'b0;
                reset       = 1'b0;
                idle_cycles($urandom_range(0, 3));
            end
        end

        idle_cycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
